sigma_tree: RTL and testbench
=============================

SIGMA_TREE -- requirements
Module: sigma_tree

Interface
REQ-001 SHALL have parameter M, default 6, number of signed-magnitude inputs summed (M >= 2).
REQ-002 SHALL have parameter N, default `N, total word width, with MSB as sign.
REQ-003 SHALL have parameter F, default `F, number of fraction bits; this value is informational only, since addition is alignment-free.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit, meaning in_data holds a sample.
REQ-007 SHALL have port in_ready, output, 1 bit, meaning the block accepts a sample this cycle.
REQ-008 SHALL have port in_data, input, M x N, the operand vector, element 0 first.
REQ-009 SHALL have port out_valid, output, 1 bit, meaning out_data holds a result.
REQ-010 SHALL have port out_ready, input, 1 bit, meaning the downstream accepts the result.
REQ-011 SHALL have port out_data, output, N bits, the signed-magnitude sum.
REQ-012 SHALL have port out_ovf, output, 1 bit, set when any add in the sample's tree overflowed.

Function
REQ-013 SHALL form a binary adder tree of L = ceil(log2 M) levels, with one register stage per level.
REQ-014 SHALL pair adjacent operands at each level as (0,1), (2,3), ...; an unpaired last operand SHALL pass through unchanged.
REQ-015 SHALL add like signs by adding magnitudes and keeping the sign.
REQ-016 SHALL add unlike signs by taking larger minus smaller magnitude, with the sign of the larger.
REQ-017 SHALL treat -0 inputs as zero and never output -0; a zero result is 0x0 with sign 0.
REQ-018 SHALL flag overflow at an add when the magnitude sum is >= 2^(N-1); the per-sample flag SHALL OR-propagate through the stages to out_ovf.
REQ-019 SHALL have latency of exactly L cycles from acceptance (in_valid && in_ready) to out_valid, absent stalls.
REQ-020 SHALL drive in_ready = !out_valid || out_ready, and all stages SHALL advance together only when in_ready = 1.
REQ-021 SHALL carry a valid bit per stage; bubbles propagate and SHALL never assert out_valid.
REQ-022 SHALL hold out_data and out_ovf stable while out_valid && !out_ready.
REQ-023 SHALL allow accept and emit in the same cycle at full throughput of 1 sample/cycle.

Reset
REQ-024 SHALL asynchronously clear all stage valid bits, data registers and overflow bits on rst; out_valid = 0, out_data = 0, out_ovf = 0.
REQ-025 SHALL discard in-flight samples on reset mid-operation, and in_ready SHALL read 1 during and after reset.

Configuration
REQ-026 SHALL, with SIGMA_SAT_EN defined, clamp an overflowing add to magnitude 2^(N-1)-1 with the computed sign.
REQ-027 SHALL, without SIGMA_SAT_EN, wrap the magnitude modulo 2^(N-1); out_ovf is reported in both builds.

Structure
REQ-028 SHALL take from shared package sigma_pkg: typedef sm_t (N-bit word), constant SM_MAX_MAG, and function sm_add returning sum and ovf.
REQ-029 SHALL use one sub-module, sigma_stage, parametrised by input count, implementing one registered tree level with its valid and ovf bits.

Verification (N=16, F=8, M=6, L=3)
REQ-030 SHALL verify: six inputs of 0x0100 -> out_data 0x0600, out_ovf 0, out_valid exactly 3 cycles after acceptance.
REQ-031 SHALL verify: inputs 0x0180, 0x8080, then zeros -> out_data 0x0100; inputs 0x0100, 0x8100, then zeros -> 0x0000, never 0x8000.
REQ-032 SHALL verify: six inputs of 0x7FFF -> out_data 0x7FFF with out_ovf 1 under SIGMA_SAT_EN, and 0x7FFA with out_ovf 1 without it.
REQ-033 SHALL verify: 5 back-to-back samples with out_ready = 0 -> in_ready drops once out_valid is set, exactly 3 samples are held, and on release all 5 emerge in order with none lost or duplicated.
REQ-034 SHALL verify: rst pulsed mid-stream with 2 samples in flight -> out_valid 0 immediately and no stale result after release.
REQ-035 SHALL verify: M=5 with inputs 0x0100 x4 and 0x8300 -> out_data 0x0100 after 3 cycles, exercising the pass-through path.

Source files
------------

// File: rtl/sigma_pkg.sv
// -----------------------------------------------------------------------------
// sigma_pkg -- shared types and arithmetic for the signed-magnitude adder tree.
//
// Contents
//   sm_t        : N-bit signed-magnitude word, MSB is the sign.
//   SM_MAX_MAG  : largest representable magnitude, 2^(N-1)-1.
//   sm_add_t    : result of one add, {sum, ovf}.
//   sm_add()    : adds two signed-magnitude words.
//   sigma_levels() / sigma_count() : tree shape helpers.
//
// Build-time macros
//   N, F          : default word width / fraction bits (16 / 8 if undefined).
//   SIGMA_SAT_EN  : when defined, an overflowing add clamps to SM_MAX_MAG;
//                   otherwise the magnitude wraps modulo 2^(N-1).
// -----------------------------------------------------------------------------
`ifndef N
`define N 16
`endif
`ifndef F
`define F 8
`endif

package sigma_pkg;

  localparam int SM_N = `N;

  typedef logic [SM_N-1:0] sm_t;

  localparam logic [SM_N-2:0] SM_MAX_MAG = '1;

  typedef struct packed {
    sm_t  sum;
    logic ovf;
  } sm_add_t;

  // Number of tree levels, ceil(log2(m)).
  function automatic int sigma_levels(input int m);
    int l;
    l = 0;
    while ((1 << l) < m) l++;
    return l;
  endfunction

  // Operand count entering level lvl (level 0 sees all m inputs).
  function automatic int sigma_count(input int m, input int lvl);
    return (m + (1 << lvl) - 1) >> lvl;
  endfunction

  // Signed-magnitude add. A zero magnitude always leaves with sign 0, so -0
  // inputs behave as zero and -0 is never produced.
  function automatic sm_add_t sm_add(input sm_t a, input sm_t b);
    logic [SM_N-2:0] ma;
    logic [SM_N-2:0] mb;
    logic [SM_N-2:0] mag;
    logic [SM_N-1:0] wide;
    logic            sign;
    logic            ovf;
    sm_add_t         r;
    ma   = a[SM_N-2:0];
    mb   = b[SM_N-2:0];
    ovf  = 1'b0;
    wide = '0;
    if (a[SM_N-1] == b[SM_N-1]) begin
      // Like signs: magnitudes add, carry out of the magnitude field is overflow.
      wide = {1'b0, ma} + {1'b0, mb};
      ovf  = wide[SM_N-1];
      mag  = wide[SM_N-2:0];
      sign = a[SM_N-1];
`ifdef SIGMA_SAT_EN
      if (ovf) mag = SM_MAX_MAG;
`endif
    end else if (ma >= mb) begin
      mag  = ma - mb;
      sign = a[SM_N-1];
    end else begin
      mag  = mb - ma;
      sign = b[SM_N-1];
    end
    if (mag == '0) sign = 1'b0;
    r.sum = {sign, mag};
    r.ovf = ovf;
    return r;
  endfunction

endpackage

// File: rtl/sigma_tree_stage.sv
// -----------------------------------------------------------------------------
// sigma_stage -- one registered level of the signed-magnitude adder tree.
//
// Pairs operands (0,1), (2,3), ...; an odd last operand passes through
// unchanged. The level's valid bit and the sample's accumulated overflow flag
// travel with the data.
//
// Parameters
//   K  : operands entering this level (>= 2).
//   N  : word width, must equal sigma_pkg::SM_N.
//   KO : operands leaving this level; derived, do not override.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset.
//   en                : advance the level (whole pipeline moves together).
//   in_valid, in_ovf  : valid / overflow-so-far of the incoming sample.
//   in_data           : K operands, element 0 first.
//   out_valid, out_ovf, out_data : registered level outputs.
// -----------------------------------------------------------------------------
module sigma_stage
  import sigma_pkg::*;
#(
  parameter int K  = 2,
  parameter int N  = SM_N,
  parameter int KO = (K + 1) / 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic                 in_ovf,
  input  logic [K-1:0][N-1:0]  in_data,
  output logic                 out_valid,
  output logic                 out_ovf,
  output logic [KO-1:0][N-1:0] out_data
);

  logic [KO-1:0][N-1:0] data_next;
  logic [KO-1:0]        add_ovf;
  logic                 ovf_next;

  logic [KO-1:0][N-1:0] data_reg;
  logic                 valid_reg;
  logic                 ovf_reg;

  genvar gi;
  generate
    for (gi = 0; gi < KO; gi++) begin : g_pair
      if (2 * gi + 1 < K) begin : g_add
        sm_add_t r;
        assign r             = sm_add(in_data[2*gi], in_data[2*gi+1]);
        assign data_next[gi] = r.sum;
        assign add_ovf[gi]   = r.ovf;
      end else begin : g_pass
        assign data_next[gi] = in_data[2*gi];
        assign add_ovf[gi]   = 1'b0;
      end
    end
  endgenerate

  assign ovf_next = in_ovf | (|add_ovf);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      data_reg  <= '0;
    end else if (en) begin
      valid_reg <= in_valid;
      ovf_reg   <= ovf_next;
      data_reg  <= data_next;
    end
  end

  assign out_valid = valid_reg;
  assign out_ovf   = ovf_reg;
  assign out_data  = data_reg;

endmodule

// File: rtl/sigma_tree.sv
// -----------------------------------------------------------------------------
// sigma_tree -- pipelined signed-magnitude adder tree over M operands.
//
// L = ceil(log2 M) registered levels; result appears L cycles after
// acceptance when not stalled. Valid/ready on both sides; the whole pipeline
// advances together whenever in_ready is high, so it sustains 1 sample/cycle.
//
// Parameters
//   M : number of operands (>= 2).
//   N : word width, MSB is sign (must equal sigma_pkg::SM_N).
//   F : fraction bits, informational only (addition needs no alignment).
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset.
//   in_valid, in_ready  : input handshake.
//   in_data             : M operands, element 0 first.
//   out_valid, out_ready: output handshake.
//   out_data            : signed-magnitude sum (never -0).
//   out_ovf             : some add in this sample's tree overflowed.
//
// Macro SIGMA_SAT_EN: saturate overflowing adds instead of wrapping.
// -----------------------------------------------------------------------------
module sigma_tree
  import sigma_pkg::*;
#(
  parameter int M = 6,
  parameter int N = `N,
  parameter int F = `F
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [M-1:0][N-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        out_data,
  output logic                out_ovf
);

  localparam int L = sigma_levels(M);

  // Fraction bits never affect the arithmetic; this empty block only marks
  // an out-of-range F for anyone reading the elaborated hierarchy.
  generate
    if (F >= N) begin : g_f_exceeds_width
    end
  endgenerate

  logic adv;

  // Output register empty or being drained: every level can shift forward.
  assign in_ready = !out_valid || out_ready;
  assign adv      = in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < L; gi++) begin : g_lvl
      localparam int KI = sigma_count(M, gi);
      localparam int KO = sigma_count(M, gi + 1);

      logic [KO-1:0][N-1:0] q;
      logic                 v;
      logic                 o;

      if (gi == 0) begin : g_first
        sigma_stage #(
          .K (KI),
          .N (N)
        ) u_stage (
          .clk       (clk),
          .rst       (rst),
          .en        (adv),
          .in_valid  (in_valid),
          .in_ovf    (1'b0),
          .in_data   (in_data),
          .out_valid (v),
          .out_ovf   (o),
          .out_data  (q)
        );
      end else begin : g_next
        sigma_stage #(
          .K (KI),
          .N (N)
        ) u_stage (
          .clk       (clk),
          .rst       (rst),
          .en        (adv),
          .in_valid  (g_lvl[gi-1].v),
          .in_ovf    (g_lvl[gi-1].o),
          .in_data   (g_lvl[gi-1].q),
          .out_valid (v),
          .out_ovf   (o),
          .out_data  (q)
        );
      end
    end
  endgenerate

  assign out_valid = g_lvl[L-1].v;
  assign out_ovf   = g_lvl[L-1].o;
  assign out_data  = g_lvl[L-1].q[0];

endmodule

// File: tb/tb_sigma_tree.sv
// -----------------------------------------------------------------------------
// tb_sigma_tree -- self-checking bench for sigma_tree (N=16, M=6 and M=5).
// -----------------------------------------------------------------------------
`ifndef N
`define N 16
`endif
`ifndef F
`define F 8
`endif

module tb_sigma_tree;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [5:0][15:0] in_data;
  logic [15:0]      out_data;

  logic             v5, r5, ov5, or5, oovf5;
  logic [4:0][15:0] d5;
  logic [15:0]      od5;

  sigma_tree #(.M(6), .N(16), .F(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  sigma_tree #(.M(5), .N(16), .F(8)) dut5 (
    .clk(clk), .rst(rst), .in_valid(v5), .in_ready(r5),
    .in_data(d5), .out_valid(ov5), .out_ready(or5),
    .out_data(od5), .out_ovf(oovf5)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_emit  = 0;

  typedef struct packed {
    logic        ovf;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // ---------------- behavioural model (plain integer arithmetic) ------------
  function automatic int model_add(input int a, input int b, inout bit ovf);
    int r;
    int mag;
    r   = a + b;
    mag = (r < 0) ? -r : r;
    if (mag >= 32768) begin
      ovf = 1'b1;
`ifdef SIGMA_SAT_EN
      mag = 32767;
`else
      mag = mag % 32768;
`endif
    end
    return (r < 0) ? -mag : mag;
  endfunction

  function automatic exp_t model(input logic [15:0] ops[$]);
    int   v[$];
    int   nv[$];
    bit   ovf;
    int   mag;
    exp_t e;
    ovf = 1'b0;
    foreach (ops[i]) v.push_back(ops[i][15] ? -int'(ops[i][14:0]) : int'(ops[i][14:0]));
    while (v.size() > 1) begin
      nv.delete();
      for (int i = 0; i < v.size(); i += 2) begin
        if (i + 1 < v.size()) nv.push_back(model_add(v[i], v[i+1], ovf));
        else                  nv.push_back(v[i]);
      end
      v = nv;
    end
    mag    = (v[0] < 0) ? -v[0] : v[0];
    e.data = {(v[0] < 0), mag[14:0]};
    e.ovf  = ovf;
    return e;
  endfunction

  function automatic exp_t model6(input logic [5:0][15:0] d);
    logic [15:0] q[$];
    for (int i = 0; i < 6; i++) q.push_back(d[i]);
    return model(q);
  endfunction

  function automatic logic [15:0] rnd_elem();
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0:       return {s, 15'($urandom_range(0, 300))};
      1:       return {s, 15'($urandom_range(28000, 32767))};
      2:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  // ---------------- compare process ----------------------------------------
  logic        prev_hold;
  logic [15:0] prev_data;
  logic        prev_ovf;
  exp_t        e_mon;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (prev_hold) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, prev_data);
        check("hold_ovf", out_ovf, prev_ovf);
      end
      if (out_valid && out_ready) begin
        n_emit++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got 0x%0h, required no output", out_data);
        end else begin
          e_mon = exp_q.pop_front();
          check("sum_data", out_data, e_mon.data);
          check("sum_ovf", out_ovf, e_mon.ovf);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model6(in_data));
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_ovf  = out_ovf;
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  function automatic logic [5:0][15:0] fill6(input logic [15:0] x);
    logic [5:0][15:0] d;
    for (int i = 0; i < 6; i++) d[i] = x;
    return d;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [5:0][15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  // Counts cycles after acceptance until out_valid; realigns to posedge+1.
  task automatic wait_out(output int k, output logic [15:0] d, output logic o);
    k = 0; d = '0; o = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (out_valid) begin
        k = c; d = out_data; o = out_ovf;
        @(posedge clk); #1;
        return;
      end
    end
    check("output_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- main sequence -------------------------------------------
  int               lat;
  logic [15:0]      got;
  logic             got_ovf;
  logic [5:0][15:0] d;
  int               idx, base;
  logic             acc;
  exp_t             pin;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    v5 = 1'b0; d5 = '0; or5 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, 16'h0000);
    check("reset_out_ovf", out_ovf, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Hand-computed anchors for the model itself.
    d = fill6(16'h0000); d[0] = 16'h0180; d[1] = 16'h8080;
    pin = model6(d);
    check("model_pin_mixed", pin.data, 16'h0100);
    pin = model6(fill6(16'h7FFF));
`ifdef SIGMA_SAT_EN
    check("model_pin_ovf", pin.data, 16'h7FFF);
`else
    check("model_pin_ovf", pin.data, 16'h7FFA);
`endif

    // Six equal positives, latency.
    send(fill6(16'h0100));
    wait_out(lat, got, got_ovf);
    $display("[TB] six x 0x0100 -> 0x%04h ovf=%0d latency=%0d", got, got_ovf, lat);
    check("basic_data", got, 16'h0600);
    check("basic_ovf", got_ovf, 1'b0);
    check("basic_latency", lat, 3);

    // Unlike signs.
    d = fill6(16'h0000); d[0] = 16'h0180; d[1] = 16'h8080;
    send(d);
    wait_out(lat, got, got_ovf);
    $display("[TB] 0x0180+0x8080 -> 0x%04h", got);
    check("unlike_data", got, 16'h0100);
    d = fill6(16'h0000); d[0] = 16'h0100; d[1] = 16'h8100;
    send(d);
    wait_out(lat, got, got_ovf);
    $display("[TB] 0x0100+0x8100 -> 0x%04h", got);
    check("cancel_to_pos_zero", got, 16'h0000);

    // Overflow.
    send(fill6(16'h7FFF));
    wait_out(lat, got, got_ovf);
    $display("[TB] six x 0x7FFF -> 0x%04h ovf=%0d", got, got_ovf);
`ifdef SIGMA_SAT_EN
    check("ovf_data", got, 16'h7FFF);
`else
    check("ovf_data", got, 16'h7FFA);
`endif
    check("ovf_flag", got_ovf, 1'b1);

    // Back-pressure: five samples with downstream stalled.
    base = n_emit; out_ready = 1'b0; idx = 0;
    in_valid = 1'b1; in_data = fill6(16'h0001);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 5) in_data = fill6(16'(idx + 1)); else in_valid = 1'b0;
      end
    end
    $display("[TB] stalled: held=%0d in_ready=%0d out_valid=%0d", idx, in_ready, out_valid);
    check("stall_held", idx, 3);
    check("stall_in_ready", in_ready, 1'b0);
    check("stall_out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 5; c++) begin
      @(negedge clk); acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 5) in_data = fill6(16'(idx + 1)); else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    $display("[TB] released: emitted=%0d", n_emit - base);
    check("stall_emitted", n_emit - base, 5);

    // Reset with two samples in flight.
    send(fill6(16'h0011));
    send(fill6(16'h0022));
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("midrst_out_data", out_data, 16'h0000);
    rst = 1'b0;
    base = n_emit;
    repeat (6) @(posedge clk);
    #1;
    $display("[TB] after mid-stream reset: emitted=%0d", n_emit - base);
    check("midrst_no_stale", n_emit - base, 0);

    // M=5, unpaired operand passes through level 1.
    d5 = '0; d5[0] = 16'h0100; d5[1] = 16'h0100; d5[2] = 16'h0100;
    d5[3] = 16'h0100; d5[4] = 16'h8300;
    v5 = 1'b1;
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (r5) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    v5 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ov5) begin lat = c; break; end
    end
    $display("[TB] M=5 -> 0x%04h ovf=%0d latency=%0d", od5, oovf5, lat);
    check("m5_data", od5, 16'h0100);
    check("m5_ovf", oovf5, 1'b0);
    check("m5_latency", lat, 3);
    @(posedge clk); #1;

    // Randomized traffic with random back-pressure.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 6; i++) d[i] = rnd_elem();
      in_data = d;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
    $display("[TB] random phase done, emitted total=%0d", n_emit);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
